// File: rtl/fp_pkg.sv
// Shared FP32 constants and the accumulator state encoding.
package fp_pkg;
  localparam int              FP_W    = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} accum_state_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with denormal, infinity and NaN handling.
module FP_adder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] A,
  input  logic [FP_W-1:0] B,
  output logic [FP_W-1:0] out
);
  logic [31:0] big, sml;
  logic [7:0]  ex, ey, d;
  logic [26:0] xx, yy, ysh, n;
  logic [27:0] s;
  logic [4:0]  pos, lz, sh;
  logic [8:0]  e;
  logic [24:0] r;
  logic        nan_a, nan_b, inf_a, inf_b, up;

  always_comb begin
    nan_a = (&A[30:23]) & (|A[22:0]);
    nan_b = (&B[30:23]) & (|B[22:0]);
    inf_a = (&A[30:23]) & ~(|A[22:0]);
    inf_b = (&B[30:23]) & ~(|B[22:0]);
    big   = (B[30:0] > A[30:0]) ? B : A;
    sml   = (B[30:0] > A[30:0]) ? A : B;
    // denormals share exponent 1 with a zero hidden bit
    ex    = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    ey    = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    d     = ex - ey;
    xx    = {big[30:23] != 8'd0, big[22:0], 3'b000};
    yy    = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    if (d >= 8'd27) ysh = {26'd0, |yy};
    else begin
      ysh    = yy >> d;
      ysh[0] = ysh[0] | (|(yy & ~(27'h7FF_FFFF << d)));
    end
    s = (big[31] ^ sml[31]) ? ({1'b0, xx} - {1'b0, ysh}) : ({1'b0, xx} + {1'b0, ysh});
    e = {1'b0, ex};
    pos = 5'd0;
    for (int i = 0; i < 27; i++) if (s[i]) pos = 5'(i);
    lz = 5'd26 - pos;
    sh = 5'd0;
    n  = s[26:0];
    if (s[27]) begin
      n = s[27:1] | {26'd0, s[0]};
      e = e + 9'd1;
    end else begin
      // never normalise below exponent 1; what remains is a denormal
      sh = ({4'd0, lz} < (e - 9'd1)) ? lz : 5'(e - 9'd1);
      n  = s[26:0] << sh;
      e  = e - {4'd0, sh};
      if (!n[26]) e = 9'd0;
    end
    up = n[2] & (n[3] | n[1] | n[0]);
    r  = {1'b0, n[26:3]} + {24'd0, up};
    if (r[24]) e = e + 9'd1;
    else if ((e == 9'd0) && r[23]) e = 9'd1;
    out = {big[31], e[7:0], r[24] ? r[23:1] : r[22:0]};
    if (e >= 9'd255) out = {big[31], 8'hFF, 23'd0};
    if (s == 28'd0) out = {A[31] & B[31], 31'd0};
    if (inf_a) out = A;
    if (inf_b) out = B;
    if (inf_a && inf_b && (A[31] != B[31])) out = FP_QNAN;
    if (nan_a || nan_b) out = FP_QNAN;
  end
endmodule

// File: rtl/fp_accum.sv
// Sequential FP32 accumulator: sums a programmed number of terms in arrival
// order through one registered FP_adder stage, with valid/ready on both sides.
module fp_accum
  import fp_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [FP_W-1:0]  in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [FP_W-1:0]  out_data,
  output logic             busy
);
  accum_state_t     state, nxt;
  logic [LEN_W-1:0] cnt;
  logic [FP_W-1:0]  acc, term_reg, sum;
  logic             term_v, accept;

  FP_adder u_add (.A(acc), .B(term_reg), .out(sum));

  assign accept   = in_vld & in_rdy;
  assign out_data = acc;
  assign busy     = (state != IDLE);

  always_comb begin
    nxt     = state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state)
      IDLE:  if (start) nxt = (len == '0) ? DONE : ACCUM;
      ACCUM: begin
        in_rdy = 1'b1;
        if (in_vld && (cnt == LEN_W'(1))) nxt = DRAIN;
      end
      DRAIN: nxt = DONE;
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= FP_ZERO;
      cnt      <= '0;
      term_reg <= FP_ZERO;
      term_v   <= 1'b0;
    end else begin
      state  <= nxt;
      term_v <= accept;
      // the last term lands in term_reg one cycle later; DRAIN covers that add
      if (term_v) acc <= sum;
      if (accept) begin
        term_reg <= in_data;
        cnt      <= cnt - LEN_W'(1);
      end
      if ((state == IDLE) && start) begin
        acc <= FP_ZERO;
        cnt <= len;
      end
    end
  end
endmodule
